// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken-branch and
// data-memory wait handling, with MEM wait timeout and saturating perf counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_memRead,
  input  logic [REG_ADDR_W-1:0] ex_wn,
  input  logic                  branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_we,
  output logic                  if_id_we,
  output logic                  if_id_flush,
  output logic                  id_ex_we,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_we,
  output logic                  mem_wb_bubble,
  output logic                  mem_err,
  output logic                  state,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int unsigned     WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} stateT;

  stateT             curState;
  logic [WAIT_W-1:0] waitCnt;
  logic              tmo;
  logic              memWait;
  logic              loadUse;
  logic              flushEvt;

  assign state    = curState;
  assign tmo      = (curState == MEM_WAIT) && (waitCnt == WAIT_LAST);
  assign memWait  = ((curState == RUN) && mem_req && !mem_ready) ||
                    ((curState == MEM_WAIT) && !mem_ready && !tmo);
  assign loadUse  = ex_memRead && (ex_wn != '0) &&
                    ((ex_wn == id_rs) || (id_uses_rt && (ex_wn == id_rt)));
  assign flushEvt = !memWait && branch_taken;

  // Pipeline register controls; priority memwait > branch > load-use > normal.
  always_comb begin
    pc_we         = 1'b1;
    if_id_we      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_we      = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_we     = 1'b1;
    mem_wb_bubble = 1'b0;
    if (!rst) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_we      = 1'b0;
      id_ex_bubble  = 1'b1;
      ex_mem_we     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (memWait) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_ex_we      = 1'b0;
      ex_mem_we     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (loadUse) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  // Wait FSM, timeout error flag and saturating counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      curState  <= RUN;
      waitCnt   <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (curState)
        RUN: begin
          if (mem_req && !mem_ready) begin
            curState <= MEM_WAIT;
            waitCnt  <= '0;
          end
        end
        MEM_WAIT: begin
          waitCnt <= waitCnt + WAIT_W'(1);
          if (mem_ready) begin
            curState <= RUN;
          end else if (tmo) begin
            curState <= RUN;
            mem_err  <= 1'b1;
          end
        end
        default: curState <= RUN;
      endcase
      if (!pc_we && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flushEvt && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4 for short runs).
module tb_pipeline_hazard_ctrl;

  localparam int unsigned RW = 5;
  localparam int unsigned CW = 4;
  localparam int unsigned TO = 4;

  localparam logic [6:0] CTL_WAIT = 7'b0000001;
  localparam logic [6:0] CTL_BR   = 7'b1111110;
  localparam logic [6:0] CTL_LU   = 7'b0001110;
  localparam logic [6:0] CTL_NORM = 7'b1101010;
  localparam logic [6:0] CTL_RST  = 7'b0010101;

  typedef struct {
    logic [6:0]    ctl;
    logic          st;
    logic          err;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } expT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [RW-1:0] id_rs = '0, id_rt = '0, ex_wn = '0;
  logic id_uses_rt = 1'b0, ex_memRead = 1'b0, branch_taken = 1'b0;
  logic mem_req = 1'b0, mem_ready = 1'b0;
  logic pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble;
  logic mem_err, state;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad = 0;
  expT sbQ[$];

  // Reference model state
  logic mState = 1'b0;
  int   mWait = 0;
  logic mErr = 1'b0;
  int   mStall = 0;
  int   mFlush = 0;

  pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memRead(ex_memRead), .ex_wn(ex_wn), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_we(id_ex_we), .id_ex_bubble(id_ex_bubble), .ex_mem_we(ex_mem_we),
    .mem_wb_bubble(mem_wb_bubble), .mem_err(mem_err), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [6:0] obsCtl();
    return {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble};
  endfunction

  // Drive one cycle (called right after a negedge), score it, then advance the model.
  task automatic cycle(input logic ld, input logic [RW-1:0] wn, input logic [RW-1:0] rs,
                       input logic [RW-1:0] rt, input logic ut, input logic br,
                       input logic req, input logic rdy, input string tag);
    expT e;
    expT o;
    logic tm, mw, lu;
    ex_memRead = ld; ex_wn = wn; id_rs = rs; id_rt = rt; id_uses_rt = ut;
    branch_taken = br; mem_req = req; mem_ready = rdy;
    tm = mState && (mWait == int'(TO) - 1);
    mw = (!mState && req && !rdy) || (mState && !rdy && !tm);
    lu = ld && (wn != '0) && ((wn == rs) || (ut && (wn == rt)));
    e.ctl = mw ? CTL_WAIT : br ? CTL_BR : lu ? CTL_LU : CTL_NORM;
    e.st  = mState;
    e.err = mErr;
    e.sc  = CW'(mStall);
    e.fc  = CW'(mFlush);
    sbQ.push_back(e);
    #1;
    if (sbQ.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      o = sbQ.pop_front();
      check({tag, "_ctl"}, 32'(obsCtl()), 32'(o.ctl));
      check({tag, "_state"}, 32'(state), 32'(o.st));
      check({tag, "_err"}, 32'(mem_err), 32'(o.err));
      check({tag, "_stall"}, 32'(stall_cnt), 32'(o.sc));
      check({tag, "_flush"}, 32'(flush_cnt), 32'(o.fc));
    end
    if (!mState) begin
      if (req && !rdy) begin mState = 1'b1; mWait = 0; end
    end else begin
      mWait++;
      if (rdy) mState = 1'b0;
      else if (tm) begin mState = 1'b0; mErr = 1'b1; end
    end
    if (e.ctl[6] == 1'b0 && mStall < (1 << CW) - 1) mStall++;
    if (!mw && br && mFlush < (1 << CW) - 1) mFlush++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    // Reset values while rst is low
    #2;
    check("rst_ctl", 32'(obsCtl()), 32'(CTL_RST));
    check("rst_state", 32'(state), 32'd0);
    check("rst_cnt", 32'({stall_cnt, flush_cnt}), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    cycle(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "lu_rs");
    check("lu_stall1", 32'(stall_cnt), 32'd1);
    idle("after_lu");
    cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "lu_r0");
    cycle(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, "br_lu");
    check("br_flush1", 32'(flush_cnt), 32'd1);
    check("br_stall1", 32'(stall_cnt), 32'd1);

    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, "mwait");
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, "mrel");
    check("mrel_stall4", 32'(stall_cnt), 32'd4);
    check("mrel_state", 32'(state), 32'd0);

    cycle(1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, "lu_rt");
    cycle(1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, "rt_unused");
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, "rdy_noreq");

    // Wait held with branch pending; branch acts on the release cycle
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0, "wait_br");
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0, "wait_br");
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1, "rel_br");

    for (int i = 0; i < 7; i++) cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, "tmo");
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, "tmo_rel");
    check("tmo_err", 32'(mem_err), 32'd1);
    idle("err_sticky");
    check("err_sticky_v", 32'(mem_err), 32'd1);

    for (int i = 0; i < 20; i++) cycle(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "sat_st");
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, "sat_fl");
    check("sat_stall", 32'(stall_cnt), 32'd15);
    check("sat_flush", 32'(flush_cnt), 32'd15);

    // Async reset between edges while in MEM_WAIT
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, "pre_rst");
    check("pre_rst_state", 32'(state), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_err", 32'(mem_err), 32'd0);
    check("arst_cnt", 32'({stall_cnt, flush_cnt}), 32'd0);
    check("arst_ctl", 32'(obsCtl()), 32'(CTL_RST));
    mState = 1'b0; mWait = 0; mErr = 1'b0; mStall = 0; mFlush = 0;
    @(negedge clk);
    rst = 1'b1;
    idle("post_rst");
    cycle(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "post_lu");
    idle("post_idle");

    if (sbQ.size() != 0) check("sb_leftover", 32'(sbQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
